// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM generator (pwm_multi_gen).
// The PWM_CENTER_ALIGN_EN build also uses dir_e for the up/down counter.
package pwm_pkg;

  localparam int PWM_W = 8;

  typedef logic [PWM_W-1:0] cnt_t;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_chan_cmp.sv
// One PWM channel: compares the shared counter against this channel's duty
// and registers the result, so every output sees the same one-cycle lag.
module pwm_chan_cmp
  import pwm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] rng,
  input  logic [W-1:0] value,
  input  logic         mode,
  input  logic         en,
  output logic         pwm_out
);

  logic center;
  logic level;

  // A zero range in centre mode has no down-count, so it falls back to edge compare.
  always_comb begin
    center = (mode == PWM_CENTER) && (rng != '0);
    if (center) begin
      level = (value >= rng) || (cnt >= (rng - value));
    end else begin
      level = (cnt < value);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= en && level;
    end
  end

endmodule

// File: rtl/pwm_multi_gen.sv
// N-channel PWM with shared period counter and shadowed period-boundary updates.
// Optional centre-aligned mode is built in when PWM_CENTER_ALIGN_EN is defined.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int W   = 8,
  parameter int NCH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_en,
  input  logic [W-1:0]     pwm_range,
  input  logic [NCH*W-1:0] pwm_value,
  input  logic             pwm_update,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic             pwm_center,
`endif
  output logic             pwm_upd_done,
  output logic             pwm_period,
  output logic [NCH-1:0]   pwm_out
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0]     cnt_q, cnt_d;
  logic [W-1:0]     act_range_q, sh_range_q;
  logic [NCH*W-1:0] act_value_q, sh_value_q;
  logic             pending_q;
  logic             upd_done_q;
  logic             act_mode;
  logic             center_run;
  logic             boundary;
  logic             xfer;

`ifdef PWM_CENTER_ALIGN_EN
  dir_e dir_q, dir_d;
  logic act_mode_q, sh_mode_q;

  assign act_mode   = act_mode_q;
  assign center_run = (act_mode_q == PWM_CENTER) && (act_range_q != '0);
`else
  assign act_mode   = PWM_EDGE;
  assign center_run = 1'b0;
`endif

  // Period boundary: top of the ramp in edge mode, bottom of the down-ramp in centre mode.
  always_comb begin
    boundary = (cnt_q == act_range_q);
`ifdef PWM_CENTER_ALIGN_EN
    if (center_run) begin
      boundary = (dir_q == DIR_DOWN) && (cnt_q == '0);
    end
`endif
    pwm_period = !reset && pwm_en && boundary;
    xfer       = (pwm_update || pending_q) && (pwm_period || !pwm_en);
  end

  always_comb begin
    cnt_d = cnt_q + ONE;
`ifdef PWM_CENTER_ALIGN_EN
    dir_d = dir_q;
`endif
    if (!pwm_en || pwm_period) begin
      cnt_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d = DIR_UP;
`endif
    end
`ifdef PWM_CENTER_ALIGN_EN
    else if (center_run) begin
      // The top value is held for two cycles while the direction turns around.
      if (dir_q == DIR_UP) begin
        if (cnt_q == (act_range_q - ONE)) begin
          cnt_d = cnt_q;
          dir_d = DIR_DOWN;
        end
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      act_range_q <= '0;
      act_value_q <= '0;
      sh_range_q  <= '0;
      sh_value_q  <= '0;
      pending_q   <= 1'b0;
      upd_done_q  <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q       <= DIR_UP;
      act_mode_q  <= PWM_EDGE;
      sh_mode_q   <= PWM_EDGE;
`endif
    end else begin
      cnt_q      <= cnt_d;
      upd_done_q <= xfer;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q      <= dir_d;
`endif
      if (pwm_update) begin
        sh_range_q <= pwm_range;
        sh_value_q <= pwm_value;
`ifdef PWM_CENTER_ALIGN_EN
        sh_mode_q  <= pwm_center;
`endif
      end
      // A strobe landing on the transfer cycle bypasses the shadow.
      if (xfer) begin
        act_range_q <= pwm_update ? pwm_range : sh_range_q;
        act_value_q <= pwm_update ? pwm_value : sh_value_q;
`ifdef PWM_CENTER_ALIGN_EN
        act_mode_q  <= pwm_update ? pwm_center : sh_mode_q;
`endif
        pending_q   <= 1'b0;
      end else if (pwm_update) begin
        pending_q   <= 1'b1;
      end
    end
  end

  assign pwm_upd_done = upd_done_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    pwm_chan_cmp #(.W(W)) u_chan (
      .clk     (clk),
      .reset   (reset),
      .cnt     (cnt_q),
      .rng     (act_range_q),
      .value   (act_value_q[i*W +: W]),
      .mode    (act_mode),
      .en      (pwm_en),
      .pwm_out (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen (W=8, NCH=2) against a phase-based reference model.
// Centre-mode scenarios are included when PWM_CENTER_ALIGN_EN is defined.
module tb_pwm_multi_gen;

  localparam int W   = 8;
  localparam int NCH = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             pwm_en;
  logic [W-1:0]     pwm_range;
  logic [NCH*W-1:0] pwm_value;
  logic             pwm_update;
`ifdef PWM_CENTER_ALIGN_EN
  logic             pwm_center;
`endif
  logic             pwm_upd_done;
  logic             pwm_period;
  logic [NCH-1:0]   pwm_out;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Reference model: position inside the period plus active/shadow settings.
  int m_p, m_r, m_c, s_r, s_c;
  int m_v[NCH];
  int s_v[NCH];
  bit m_pend, m_done;
  bit m_out[NCH];
  bit nx_out[NCH];
  bit nx_per, nx_xfer;
  int nx_cin;

  pwm_multi_gen #(.W(W), .NCH(NCH)) dut (
    .clk          (clk),
    .reset        (reset),
    .pwm_en       (pwm_en),
    .pwm_range    (pwm_range),
    .pwm_value    (pwm_value),
    .pwm_update   (pwm_update),
`ifdef PWM_CENTER_ALIGN_EN
    .pwm_center   (pwm_center),
`endif
    .pwm_upd_done (pwm_upd_done),
    .pwm_period   (pwm_period),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int periodLen();
    if (m_c != 0 && m_r >= 1) return 2 * m_r;
    return m_r + 1;
  endfunction

  function automatic bit modelPeriod();
    return !reset && pwm_en && (m_p == periodLen() - 1);
  endfunction

  function automatic bit modelLevel(input int i);
    int c;
    if (m_c != 0 && m_r >= 1) begin
      c = (m_p < m_r) ? m_p : (2 * m_r - 1 - m_p);
      return (m_v[i] >= m_r) || (c >= m_r - m_v[i]);
    end
    return m_p < m_v[i];
  endfunction

  function automatic logic [NCH-1:0] modelOutVec();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_out[i];
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_p = 0; m_r = 0; m_c = 0; s_r = 0; s_c = 0;
      m_pend = 1'b0; m_done = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_v[i] = 0; s_v[i] = 0; m_out[i] = 1'b0;
      end
    end else begin
`ifdef PWM_CENTER_ALIGN_EN
      nx_cin = int'(pwm_center);
`else
      nx_cin = 0;
`endif
      nx_per = modelPeriod();
      for (int i = 0; i < NCH; i++) nx_out[i] = pwm_en && modelLevel(i);
      nx_xfer = (pwm_update || m_pend) && (nx_per || !pwm_en);
      if (nx_xfer) begin
        if (pwm_update) begin
          m_r = int'(pwm_range);
          m_c = nx_cin;
          for (int i = 0; i < NCH; i++) m_v[i] = int'(pwm_value[i*W +: W]);
        end else begin
          m_r = s_r;
          m_c = s_c;
          for (int i = 0; i < NCH; i++) m_v[i] = s_v[i];
        end
        m_pend = 1'b0;
      end else if (pwm_update) begin
        m_pend = 1'b1;
      end
      if (pwm_update) begin
        s_r = int'(pwm_range);
        s_c = nx_cin;
        for (int i = 0; i < NCH; i++) s_v[i] = int'(pwm_value[i*W +: W]);
      end
      m_done = nx_xfer;
      for (int i = 0; i < NCH; i++) m_out[i] = nx_out[i];
      m_p = (!pwm_en || nx_per) ? 0 : m_p + 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("pwm_out", 32'(pwm_out), 32'(modelOutVec()));
      checkOutput("pwm_period", 32'(pwm_period), 32'(modelPeriod()));
      checkOutput("upd_done", 32'(pwm_upd_done), 32'(m_done));
    end
  end

  task automatic applyStimulus(input bit en, input int rng, input int v0, input int v1,
                               input bit upd, input bit ctr);
    pwm_en     = en;
    pwm_range  = W'(rng);
    pwm_value  = {W'(v1), W'(v0)};
    pwm_update = upd;
`ifdef PWM_CENTER_ALIGN_EN
    pwm_center = ctr;
`else
    if (ctr) $display("[TB] centre request ignored in edge-only build");
`endif
    @(posedge clk); #1;
    pwm_update = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic countWindow(input int n, output int h0, output int h1, output int pc);
    h0 = 0; h1 = 0; pc = 0;
    repeat (n) begin
      @(negedge clk);
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      pc += int'(pwm_period);
      @(posedge clk); #1;
    end
  endtask

  task automatic waitPeriod(input string tag, input int budget, output int k);
    bit found = 1'b0;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (pwm_period) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) checkOutput(tag, 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic waitDone(input string tag, input int budget, output int k);
    bit found = 1'b0;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (pwm_upd_done) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!found) checkOutput(tag, 0, 1);
    else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int h0, h1, pc, k;
    reset = 1'b1; pwm_en = 1'b1; pwm_range = '0; pwm_value = '0; pwm_update = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    pwm_center = 1'b0;
`endif
    @(posedge clk); #1;
    check_en = 1'b1;

    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_out", 32'(pwm_out), 0);
      checkOutput("rst_period", 32'(pwm_period), 0);
      checkOutput("rst_done", 32'(pwm_upd_done), 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    $display("[TB] steady edge-mode PWM, range 9");
    applyStimulus(1, 9, 3, 10, 1, 0);
    idle(12);
    countWindow(10, h0, h1, pc);
    checkOutput("t2_ch0_high", h0, 3);
    checkOutput("t2_ch1_high", h1, 10);
    checkOutput("t2_periods", pc, 1);

    $display("[TB] mid-period update");
    waitPeriod("t3_wait_period", 30, k);
    idle(4);
    applyStimulus(1, 9, 7, 10, 1, 0);
    waitDone("t3_wait_done", 30, k);
    checkOutput("t3_done_latency", k, 5);
    countWindow(10, h0, h1, pc);
    checkOutput("t3_ch0_high", h0, 7);
    checkOutput("t3_periods", pc, 1);

    $display("[TB] zero duty, zero range");
    applyStimulus(1, 0, 0, 10, 1, 0);
    idle(12);
    countWindow(5, h0, h1, pc);
    checkOutput("t4_ch0_high", h0, 0);
    checkOutput("t4_ch1_high", h1, 5);
    checkOutput("t4_periods", pc, 5);

    $display("[TB] disable with pending update");
    applyStimulus(1, 9, 3, 10, 1, 0);
    idle(12);
    waitPeriod("t5_wait_period", 30, k);
    idle(4);
    applyStimulus(1, 9, 5, 2, 1, 0);
    applyStimulus(0, 9, 5, 2, 0, 0);
    @(negedge clk);
    checkOutput("t5_out_off", 32'(pwm_out), 0);
    checkOutput("t5_done", 32'(pwm_upd_done), 1);
    @(posedge clk); #1;
    idle(3);
    pwm_en = 1'b1;
    waitPeriod("t5_wait_restart", 30, k);
    checkOutput("t5_restart_len", k, 9);
    idle(5);

`ifdef PWM_CENTER_ALIGN_EN
    $display("[TB] centre-aligned mode");
    applyStimulus(1, 4, 2, 0, 1, 1);
    idle(20);
    countWindow(8, h0, h1, pc);
    checkOutput("t6_ch0_high", h0, 4);
    checkOutput("t6_ch1_high", h1, 0);
    checkOutput("t6_periods", pc, 1);
`endif

    $display("[TB] randomized phase");
    for (int n = 0; n < 500; n++) begin
      reset      = ($urandom_range(99) == 0);
      pwm_en     = ($urandom_range(9) != 0);
      pwm_update = ($urandom_range(7) == 0);
      pwm_range  = W'($urandom_range(12));
      pwm_value  = {W'($urandom_range(15)), W'($urandom_range(15))};
`ifdef PWM_CENTER_ALIGN_EN
      pwm_center = 1'($urandom_range(1));
`endif
      @(posedge clk); #1;
    end
    reset = 1'b0;
    pwm_update = 1'b0;
    idle(3);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
